writeback_queue: RTL
====================

WRITEBACK_QUEUE -- requirements
Module: writeback_queue

Interface
REQ-001 SHALL have parameter: DEPTH, 4, number of queue entries (power of 2, 2..8).
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port: alu_valid  input  1  ALU result write request.
REQ-005 SHALL have port: alu_ready  output  1  ALU request accepted this cycle.
REQ-006 SHALL have port: alu_addr  input  3  ALU destination register R0–R7.
REQ-007 SHALL have port: alu_data  input  8  ALU result.
REQ-008 SHALL have port: mem_valid  input  1  memory-load write request.
REQ-009 SHALL have port: mem_ready  output  1  memory request accepted this cycle.
REQ-010 SHALL have port: mem_addr  input  3  load destination register.
REQ-011 SHALL have port: mem_data  input  8  load data.
REQ-012 SHALL have port: wb_write_enable  output  1  register-file write strobe, registered.
REQ-013 SHALL have port: wb_write_addr  output  3  register-file write address, registered.
REQ-014 SHALL have port: wb_write_data  output  8  register-file write data, registered.
REQ-015 SHALL have port: pending_mask  output  8  bit i = write to Ri queued or presented.
REQ-016 SHALL have port: fifo_count  output  clog2(DEPTH+1)  occupied entries, 0..DEPTH.

Function
REQ-017 SHALL hold DEPTH entries of {addr[2:0], data[7:0]} in a circular FIFO with read/write pointers wrapping DEPTH-1 -> 0.
REQ-018 SHALL accept at most one request per cycle; a handshake completes at an edge where valid and ready are both 1.
REQ-019 SHALL deassert both ready outputs when fifo_count == DEPTH, even if a pop occurs that same edge (full blocks; no bypass).
REQ-020 SHALL, when not full and only one valid is high, assert that requester's ready.
REQ-021 SHALL, when not full and both valid, grant the requester not granted at the last contended cycle; last_grant updates only on contended grants.
REQ-022 SHALL keep ready outputs combinational from valids, fifo_count, last_grant; neither ready depends on its own valid.
REQ-023 SHALL complete handshakes with addr == 0 but discard them: no enqueue, count unchanged.
REQ-024 SHALL, at each edge where fifo_count > 0 (pre-edge value), pop the head into wb_write_addr/wb_write_data and set wb_write_enable = 1; otherwise set wb_write_enable = 0 and hold addr/data.
REQ-025 SHALL give latency: accept at edge N into an empty queue -> wb_write_enable = 1 during the cycle after edge N+1, exactly one cycle per entry.
REQ-026 SHALL issue writes in acceptance order; repeated writes to one register are all issued, last wins.
REQ-027 SHALL update fifo_count by +1 (push only), -1 (pop only), 0 (both or neither) on each edge.
REQ-028 SHALL drive pending_mask[i] = 1 if any occupied entry has addr i, or wb_write_enable = 1 with wb_write_addr = i; pending_mask[0] is always 0.
REQ-029 SHALL make overflow and underflow impossible; no entry is lost or duplicated.

Reset
REQ-030 SHALL, on an edge with rst = 1, clear pointers, fifo_count = 0, wb_write_enable = 0, wb_write_addr = 0, wb_write_data = 0, last_grant = ALU; queued entries discarded.
REQ-031 SHALL hold alu_ready = mem_ready = 0 while rst = 1; a request presented during reset is not accepted.
REQ-032 SHALL, with rst asserted mid-drain, make wb_write_enable 0 in the cycle after the reset edge, with pending_mask = 0.

Verification
REQ-033 SHALL pass: ALU only, addr 3 data 0x5A at edge 1 -> wb_write_enable = 1, addr 3, data 0x5A after edge 2; pending_mask = 0x08 from edge 1 until edge 3.
REQ-034 SHALL pass: both valid every cycle, addrs ALU 1 / MEM 2 -> first grant MEM, then alternating ALU, MEM, ALU; wb addrs 2,1,2,1.
REQ-035 SHALL pass: 5 ALU pushes, consecutive edges, DEPTH = 4, no drain stall -> fifo_count never exceeds 4; all 5 writes emerge in order; alu_ready low only when count = 4.
REQ-036 SHALL pass: ALU addr 0 data 0xFF accepted -> alu_ready = 1, fifo_count stays 0, no wb_write_enable.
REQ-037 SHALL pass: two writes to R5 (0x11 then 0x22) -> two strobes in order; pending_mask[5] = 1 until second strobe ends.
REQ-038 SHALL pass: rst for one edge with 3 entries queued -> fifo_count = 0, wb_write_enable = 0, pending_mask = 0 next cycle; none of those writes appear after reset.

Source files
------------

// File: rtl/writeback_queue.sv
// Writeback queue: arbitrates ALU/load results into a FIFO that drains into the register file.
// Ports: clk/rst, alu_* and mem_* request channels, wb_write_* strobe, pending_mask, fifo_count.
module writeback_queue #(
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         alu_valid,
  output logic                         alu_ready,
  input  logic [2:0]                   alu_addr,
  input  logic [7:0]                   alu_data,
  input  logic                         mem_valid,
  output logic                         mem_ready,
  input  logic [2:0]                   mem_addr,
  input  logic [7:0]                   mem_data,
  output logic                         wb_write_enable,
  output logic [2:0]                   wb_write_addr,
  output logic [7:0]                   wb_write_data,
  output logic [7:0]                   pending_mask,
  output logic [$clog2(DEPTH+1)-1:0]   fifo_count
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  typedef enum logic {
    GR_ALU = 1'b0,
    GR_MEM = 1'b1
  } grant_t;

  logic [2:0]       r_addr_mem [DEPTH];
  logic [7:0]       r_data_mem [DEPTH];
  logic [DEPTH-1:0] r_vld;
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  grant_t           r_last_grant;
  logic             r_wb_en;
  logic [2:0]       r_wb_addr;
  logic [7:0]       r_wb_data;

  logic       w_full;
  logic       w_alu_hs;
  logic       w_mem_hs;
  logic       w_contend;
  logic       w_push;
  logic       w_pop;
  logic [2:0] w_in_addr;
  logic [7:0] w_in_data;
  logic [7:0] w_mask;

  assign w_full = (r_count == FULL_CNT);

  // Each ready looks only at the other side's valid, so a lone
  // requester is always granted and a contended cycle alternates.
  assign alu_ready = !rst && !w_full &&
                     (!mem_valid || (r_last_grant == GR_MEM));
  assign mem_ready = !rst && !w_full &&
                     (!alu_valid || (r_last_grant == GR_ALU));

  assign w_alu_hs  = alu_valid && alu_ready;
  assign w_mem_hs  = mem_valid && mem_ready;
  assign w_contend = alu_valid && mem_valid && !w_full && !rst;

  always_comb begin
    w_in_addr = alu_addr;
    w_in_data = alu_data;
    if (w_mem_hs) begin
      w_in_addr = mem_addr;
      w_in_data = mem_data;
    end
  end

  // R0 is hardwired; its writes complete the handshake but are dropped.
  assign w_push = (w_alu_hs || w_mem_hs) && (w_in_addr != 3'd0);
  assign w_pop  = (r_count != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_vld        <= '0;
      r_last_grant <= GR_ALU;
      r_wb_en      <= 1'b0;
      r_wb_addr    <= '0;
      r_wb_data    <= '0;
    end else begin
      if (w_contend)
        r_last_grant <= w_mem_hs ? GR_MEM : GR_ALU;
      if (w_push) begin
        r_wr_ptr        <= r_wr_ptr + PW'(1);
        r_vld[r_wr_ptr] <= 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr        <= r_rd_ptr + PW'(1);
        r_vld[r_rd_ptr] <= 1'b0;
        r_wb_addr       <= r_addr_mem[r_rd_ptr];
        r_wb_data       <= r_data_mem[r_rd_ptr];
      end
      r_wb_en <= w_pop;
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Payload storage needs no reset; r_vld qualifies every entry.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_addr_mem[r_wr_ptr] <= w_in_addr;
      r_data_mem[r_wr_ptr] <= w_in_data;
    end
  end

  always_comb begin
    w_mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (r_vld[i])
        w_mask[r_addr_mem[i]] = 1'b1;
    end
    if (r_wb_en)
      w_mask[r_wb_addr] = 1'b1;
    w_mask[0] = 1'b0;
  end

  assign pending_mask    = w_mask;
  assign fifo_count      = r_count;
  assign wb_write_enable = r_wb_en;
  assign wb_write_addr   = r_wb_addr;
  assign wb_write_data   = r_wb_data;

endmodule
